mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 11 +
 rtl/mem_arbiter.sv | 66 ++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory-style bus (address, write data, strobes, read data, ready)
interface mem_arbiter_if #(parameter int M = 16, parameter int N = 32);
  logic [N-1:0] addr;
  logic [M-1:0] wdata;
  logic         re;
  logic         we;
  logic [M-1:0] rdata;
  logic         ready;
  modport master(output addr, wdata, re, we, input rdata, ready);
  modport slave(input addr, wdata, re, we, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master/one-slave bus arbiter, fixed priority to master 0 with a starvation guard;
// define MEM_ARB_ROUND_ROBIN_EN to alternate ties instead.
module mem_arbiter #(
  parameter int M = 16,
  parameter int N = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  mem_arbiter_if.master      mem,
  output logic [1:0]         grant
);
  typedef enum logic [1:0] {NONE = 2'b00, M0 = 2'b01, M1 = 2'b10} owner_t;
  owner_t owner, owner_nx, gnt, pick;
  logic req0, req1, req_g, done0, done1;
  logic [3:0] starve_cnt, starve_nx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_winner;
`endif
  always_comb begin
    req0 = m0.re | m0.we;
    req1 = m1.re | m1.we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick = (req0 && req1) ? ((last_winner == M1) ? M0 : M1) : req0 ? M0 : req1 ? M1 : NONE;
`else
    pick = (req1 && (starve_cnt >= 4'(STARVE_LIMIT) || !req0)) ? M1 : req0 ? M0 : NONE;
`endif
    gnt = rst ? NONE : (owner != NONE) ? owner : pick;
    req_g = (gnt == M0) ? req0 : (gnt == M1) ? req1 : 1'b0;
    done0 = mem.ready && gnt == M0 && req0;
    done1 = mem.ready && gnt == M1 && req1;
    // only a live, unfinished transaction keeps the lock; completion or abort re-arbitrates
    owner_nx = (req_g && !mem.ready) ? gnt : NONE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    starve_nx = '0;
`else
    starve_nx = (!req1 || done1) ? 4'd0 : (done0 && starve_cnt != 4'hF) ? starve_cnt + 4'd1 : starve_cnt;
`endif
  end
  assign grant     = gnt;
  assign mem.addr  = (gnt == M0) ? m0.addr  : (gnt == M1) ? m1.addr  : N'(0);
  assign mem.wdata = (gnt == M0) ? m0.wdata : (gnt == M1) ? m1.wdata : M'(0);
  assign mem.re    = (gnt == M0) ? m0.re    : (gnt == M1) ? m1.re    : 1'b0;
  assign mem.we    = (gnt == M0) ? m0.we    : (gnt == M1) ? m1.we    : 1'b0;
  assign m0.ready  = done0;
  assign m1.ready  = done1;
  assign m0.rdata  = mem.rdata;
  assign m1.rdata  = mem.rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= NONE;
      starve_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_winner <= M1;
`endif
    end else begin
      owner      <= owner_nx;
      starve_cnt <= starve_nx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_winner <= done0 ? M0 : done1 ? M1 : last_winner;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] grant;
  int pass_cnt = 0;
  int total = 0;
  mem_arbiter_if #(.M(16), .N(32)) m0_bus();
  mem_arbiter_if #(.M(16), .N(32)) m1_bus();
  mem_arbiter_if #(.M(16), .N(32)) mem_bus();
  mem_arbiter #(.M(16), .N(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .mem(mem_bus), .grant(grant)
  );
  always #5 clk = ~clk;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] ABORT_STARVE = 4'd0;
`else
  localparam logic [3:0] ABORT_STARVE = 4'd1;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.re = 0; m0_bus.we = 0;
    m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.re = 0; m1_bus.we = 0;
    mem_bus.rdata = '0; mem_bus.ready = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    tick();
    total++;
    if ({grant, mem_bus.re, mem_bus.we, m0_bus.ready, m1_bus.ready} !== 6'b0)
      $display("FAIL reset_outputs got %b want 000000", {grant, mem_bus.re, mem_bus.we, m0_bus.ready, m1_bus.ready});
    else pass_cnt++;
    total++;
    if (dut.starve_cnt !== 4'd0) $display("FAIL reset_starve got %0d want 0", dut.starve_cnt);
    else pass_cnt++;
    rst = 0;
    tick();
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({grant, mem_bus.re, mem_bus.we, mem_bus.addr, mem_bus.wdata, m0_bus.ready, m1_bus.ready} !== 54'b0)
        $display("FAIL idle_c%0d grant=%b re=%b we=%b addr=%h wdata=%h r0=%b r1=%b want all zero", i, grant,
                 mem_bus.re, mem_bus.we, mem_bus.addr, mem_bus.wdata, m0_bus.ready, m1_bus.ready);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_single_read;
    m0_bus.addr = 32'h0000_1234; m0_bus.re = 1;
    mem_bus.rdata = 16'hBEEF; mem_bus.ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({grant, mem_bus.addr, mem_bus.re, mem_bus.we, m0_bus.ready, m0_bus.rdata, m1_bus.ready} !==
          {2'b01, 32'h0000_1234, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0})
        $display("FAIL read_c%0d grant=%b addr=%h re=%b we=%b r0=%b rdata=%h r1=%b want 01 00001234 1 0 1 beef 0",
                 i, grant, mem_bus.addr, mem_bus.re, mem_bus.we, m0_bus.ready, m0_bus.rdata, m1_bus.ready);
      else pass_cnt++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_wait_states;
    m1_bus.addr = 32'hD000_0010; m1_bus.wdata = 16'h00AA; m1_bus.we = 1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin m0_bus.addr = 32'h0000_0040; m0_bus.re = 1; end
      mem_bus.ready = (c == 4);
      #1;
      total++;
      if ({grant, mem_bus.addr, mem_bus.wdata, mem_bus.we, mem_bus.re, m0_bus.ready, m1_bus.ready} !==
          {2'b10, 32'hD000_0010, 16'h00AA, 1'b1, 1'b0, 1'b0, c == 4})
        $display("FAIL wait_c%0d grant=%b addr=%h wdata=%h we=%b re=%b r0=%b r1=%b want 10 d0000010 00aa 1 0 0 %b",
                 c, grant, mem_bus.addr, mem_bus.wdata, mem_bus.we, mem_bus.re, m0_bus.ready, m1_bus.ready, c == 4);
      else pass_cnt++;
      tick();
    end
    m1_bus.we = 0;
    #1;
    total++;
    if ({grant, mem_bus.addr, m0_bus.ready} !== {2'b01, 32'h0000_0040, 1'b1})
      $display("FAIL wait_c5 grant=%b addr=%h r0=%b want 01 00000040 1", grant, mem_bus.addr, m0_bus.ready);
    else pass_cnt++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] exp_seq [10] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    logic [1:0] exp_seq [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    rst = 1;
    tick();
    rst = 0;
    m0_bus.re = 1; m0_bus.addr = 32'h100;
    m1_bus.re = 1; m1_bus.addr = 32'h200;
    mem_bus.ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({grant, m0_bus.ready, m1_bus.ready} !== {exp_seq[i], exp_seq[i][0], exp_seq[i][1]})
        $display("FAIL starve_c%0d grant=%b r0=%b r1=%b want grant %b", i, grant, m0_bus.ready, m1_bus.ready, exp_seq[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_abort;
    m0_bus.re = 1; m0_bus.addr = 32'h300;
    m1_bus.re = 1; m1_bus.addr = 32'h400;
`ifndef MEM_ARB_ROUND_ROBIN_EN
    mem_bus.ready = 1;
    tick();
`endif
    mem_bus.ready = 0;
    #1;
    total++;
    if ({grant, mem_bus.addr} !== {2'b01, 32'h300}) $display("FAIL abort_lock grant=%b addr=%h want 01 00000300", grant, mem_bus.addr);
    else pass_cnt++;
    tick();
    m0_bus.re = 0;
    #1;
    total++;
    if ({grant, mem_bus.re, m0_bus.ready} !== {2'b01, 1'b0, 1'b0})
      $display("FAIL abort_drop grant=%b re=%b r0=%b want 01 0 0", grant, mem_bus.re, m0_bus.ready);
    else pass_cnt++;
    tick();
    #1;
    total++;
    if ({grant, mem_bus.addr} !== {2'b10, 32'h400}) $display("FAIL abort_regrant grant=%b addr=%h want 10 00000400", grant, mem_bus.addr);
    else pass_cnt++;
    total++;
    if (dut.starve_cnt !== ABORT_STARVE) $display("FAIL abort_starve got %0d want %0d", dut.starve_cnt, ABORT_STARVE);
    else pass_cnt++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    m0_bus.re = 1; m0_bus.addr = 32'h500;
    m1_bus.re = 1; m1_bus.addr = 32'h600;
    mem_bus.ready = 1;
    tick();
    m0_bus.re = 0;
    mem_bus.ready = 0;
    #1;
    total++;
    if (grant !== 2'b10) $display("FAIL rstmid_pre grant=%b want 10", grant);
    else pass_cnt++;
    tick();
    rst = 1;
    mem_bus.ready = 1;
    #1;
    total++;
    if ({grant, mem_bus.re, mem_bus.we, m0_bus.ready, m1_bus.ready} !== 6'b0)
      $display("FAIL rstmid_during grant=%b re=%b we=%b r0=%b r1=%b want all zero", grant, mem_bus.re, mem_bus.we,
               m0_bus.ready, m1_bus.ready);
    else pass_cnt++;
    tick();
    rst = 0;
    mem_bus.ready = 0;
    #1;
    total++;
    if ({grant, mem_bus.re, mem_bus.addr} !== {2'b10, 1'b1, 32'h600})
      $display("FAIL rstmid_after grant=%b re=%b addr=%h want 10 1 00000600", grant, mem_bus.re, mem_bus.addr);
    else pass_cnt++;
    total++;
    if (dut.starve_cnt !== 4'd0) $display("FAIL rstmid_starve got %0d want 0", dut.starve_cnt);
    else pass_cnt++;
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #1;
    test_reset();
    test_idle();
    test_single_read();
    test_wait_states();
    test_starvation();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
